dram_rr_arbiter: RTL
====================

Name: dram_rr_arbiter

Overview:
- Round-robin, transaction-level arbiter that shares one single-port synchronous DRAM (or IRAM) among N cores.
- Sits between the cores' memory-control outputs and the RAM macro, in place of the fixed-priority memory controller.
- Grants exactly one access per grant, waits out the RAM read latency, returns registered read data and a one-cycle ack to the winner, then rotates priority.

Parameters:
- N, 3, number of requesting cores
- AW, 8, address width
- DW, 8, data width
- RD_LAT, 1, RAM read latency in clocks: q is valid RD_LAT clocks after the address edge

Ports:
- clk  in  1  system clock (divided core clock)
- rst  in  1  asynchronous, active-high reset
- rden  in  N  per-core read request; bit i belongs to core i
- wren  in  N  per-core write request
- Address  in  N*AW  per-core address, core i at [i*AW +: AW]
- Din  in  N*DW  per-core write data, core i at [i*DW +: DW]
- RAMq  in  DW  RAM read data
- acq  out  N  one-hot grant, high from ISSUE through ACK of the winner
- ack  out  N  one-hot, one-cycle completion pulse
- Dq  out  N*DW  per-core registered read data, core i at [i*DW +: DW]
- RAMAddress  out  AW  RAM address
- RAMDin  out  DW  RAM write data
- RAMwren  out  1  RAM write enable
- err  out  1  sticky flag: a request had rden and wren both set

Behaviour:
- Reset (async, any time):
  - acq=0, ack=0, Dq=0, RAMAddress=0, RAMDin=0, RAMwren=0, err=0.
  - state=IDLE, priority pointer ptr=0 (core 0 highest).
  - An in-flight write is aborted and RAMwren drops immediately.
- Request: req[i] = rden[i] | wren[i]. A core holds its request, Address and Din stable until it sees ack[i], then drops the request the next cycle.
- Round-robin pick:
  - Search starts at ptr and wraps modulo N; the first asserted req wins.
  - After each ACK, ptr = winner+1 (wrap N-1 -> 0).
- States:
  - IDLE: if any req, latch winner g, op = wren[g] (write wins over read), address and data. Next state ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 clk): acq[g]=1, RAMAddress = latched address. For a write, RAMDin = latched data and RAMwren=1, then next state ACK. For a read, RAMwren=0, then next state WAIT.
  - WAIT (RD_LAT clks, down-counter): RAMAddress held. At the final WAIT edge, Dq[g] <= RAMq. Next state ACK.
  - ACK (1 clk): ack[g]=1, acq[g] still 1. Arbitration runs in this cycle with req[g] masked. If another req is pending, the next state is ISSUE for the new winner (back-to-back, no IDLE bubble); otherwise IDLE.
- Latency, request visible in IDLE at cycle t:
  - Write: ISSUE t+1, ACK t+2.
  - Read: ISSUE t+1, WAIT t+2..t+1+RD_LAT, ACK t+2+RD_LAT.
- Outputs are registered; RAMwren is high only in ISSUE of a write.
- Dq[i] changes only at the capture edge of core i's own read and holds until that core's next read. Other cores' Dq are never disturbed.
- rden[i]&wren[i] while sampled: treated as a write, and err is set and held until reset.
- Request dropped before ack: the latched transaction still completes and ack is still pulsed.
- Starvation bound: a continuously requesting core is granted within N-1 other transactions.
- All N idle: outputs stay at reset values, except Dq holds its last captured data.

Decomposition:
- Package dram_arb_pkg:
  - state enum IDLE/ISSUE/WAIT/ACK, 2-bit encoding.
  - function computing clog2 of N for the pointer width.
- Sub-module rr_pick:
  - Combinational rotate-priority encoder.
  - Inputs: req[N], mask[N], ptr.
  - Outputs: any, grant index.
  - Reused by the IRAM arbiter instance.

Test Plan:
- Single read, core1, Address1=0x12, RAM[0x12]=0xA5, RD_LAT=1 -> acq=3'b010 at t+1..t+3, ack[1] pulse at t+3, Dq1=0xA5, Dq0 and Dq2 unchanged.
- All three cores write simultaneously, addresses 0x00/0x01/0x02 with data 0x10/0x11/0x12, ptr=0 -> grant order core0, core1, core2 with no IDLE gaps; RAMwren pulses at t+1, t+3, t+5; RAM holds 0x10, 0x11, 0x12.
- Core0 and core2 request continuously, core1 idle -> grants alternate 0,2,0,2; each ack at most one transaction apart.
- rden0=wren0=1, Address=0x30, Din=0x5C -> write performed (RAM[0x30]=0x5C), err=1 and stays 1 after further clean traffic.
- Async rst asserted mid-ISSUE of a write -> RAMwren, acq and ack go to 0 before the next edge; after release, state is IDLE and ptr=0, so core0 wins the next contention.
- RD_LAT=2 build, core2 reads -> ack[2] at t+4, and Dq2 equals RAMq as sampled 2 clocks after ISSUE.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and elaboration helpers for the round-robin RAM arbiter.
package dram_arb_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < n) ? (i + 1) : r;
    end
    return r;
  endfunction

  // Priority pointer / grant index width, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (clog2_f(n) < 1) ? 1 : clog2_f(n);
  endfunction

endpackage

// File: rtl/dram_rr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first unmasked request at or after
// ptr, wrapping modulo N. Shared by the DRAM and IRAM arbiter instances.
module rr_pick
  import dram_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] idx
);

  logic [N-1:0] eff_s;
  int           pos_s;
  logic         hit_s;

  assign eff_s = req & ~mask;

  // Walk the N positions starting at ptr; the first live request wins.
  always_comb begin
    any   = 1'b0;
    idx   = {PW{1'b0}};
    pos_s = 0;
    hit_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos_s = (int'(ptr) + k) % N;
      hit_s = eff_s[pos_s] & ~any;
      idx   = hit_s ? PW'(pos_s) : idx;
      any   = any | eff_s[pos_s];
    end
  end

endmodule

// File: rtl/dram_rr_arbiter.sv
// Round-robin, transaction-level arbiter sharing one single-port synchronous
// RAM among N cores. One access per grant; read data and ack are registered.
module dram_rr_arbiter
  import dram_arb_pkg::*;
#(
  parameter int N      = 3,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    rden,
  input  logic [N-1:0]    wren,
  input  logic [N*AW-1:0] Address,
  input  logic [N*DW-1:0] Din,
  input  logic [DW-1:0]   RAMq,
  output logic [N-1:0]    acq,
  output logic [N-1:0]    ack,
  output logic [N*DW-1:0] Dq,
  output logic [AW-1:0]   RAMAddress,
  output logic [DW-1:0]   RAMDin,
  output logic            RAMwren,
  output logic            err
);

  localparam int PW = ptr_width(N);
  localparam int CW = clog2_f(RD_LAT) + 1;

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   g_q, g_d;
  logic            wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    acq_q, acq_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [N*DW-1:0] dq_q, dq_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_din_q, ram_din_d;
  logic            ram_wren_q, ram_wren_d;
  logic            err_q, err_d;

  logic [N-1:0]    req_s;
  logic [N-1:0]    mask_s;
  logic [PW-1:0]   next_ptr_s;
  logic [PW-1:0]   pick_ptr_s;
  logic            any_s;
  logic [PW-1:0]   pick_idx_s;
  logic [N-1:0]    pick_oh_s;
  logic [N-1:0]    cur_oh_s;
  logic            pick_wr_s;
  logic            pick_both_s;
  logic [AW-1:0]   pick_addr_s;
  logic [DW-1:0]   pick_din_s;

  assign req_s      = rden | wren;
  assign cur_oh_s   = N'(1'b1) << g_q;
  assign next_ptr_s = (g_q == PW'(N - 1)) ? {PW{1'b0}} : (g_q + PW'(1'b1));

  // While acknowledging, the finishing core is masked and the search starts
  // just after it, so the next winner can be issued without an IDLE bubble.
  assign pick_ptr_s = (state_q == ACK) ? next_ptr_s : ptr_q;
  assign mask_s     = (state_q == ACK) ? cur_oh_s : {N{1'b0}};

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req  (req_s),
    .mask (mask_s),
    .ptr  (pick_ptr_s),
    .any  (any_s),
    .idx  (pick_idx_s)
  );

  assign pick_oh_s   = N'(1'b1) << pick_idx_s;
  assign pick_wr_s   = wren[pick_idx_s];
  assign pick_both_s = rden[pick_idx_s] & wren[pick_idx_s];
  assign pick_addr_s = Address[pick_idx_s*AW +: AW];
  assign pick_din_s  = Din[pick_idx_s*DW +: DW];

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    g_d        = g_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    acq_d      = acq_q;
    ack_d      = {N{1'b0}};
    dq_d       = dq_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_wren_d = ram_wren_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          // Write wins when both strobes are up; that case is also flagged.
          state_d    = ISSUE;
          g_d        = pick_idx_s;
          wr_d       = pick_wr_s;
          acq_d      = pick_oh_s;
          ram_addr_d = pick_addr_s;
          ram_din_d  = pick_wr_s ? pick_din_s : {DW{1'b0}};
          ram_wren_d = pick_wr_s;
          err_d      = err_q | pick_both_s;
        end else begin
          acq_d      = {N{1'b0}};
          ram_addr_d = {AW{1'b0}};
          ram_din_d  = {DW{1'b0}};
          ram_wren_d = 1'b0;
        end
      end
      ISSUE: begin
        ram_wren_d = 1'b0;
        if (wr_q) begin
          state_d = ACK;
          ack_d   = cur_oh_s;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          dq_d[g_q*DW +: DW] = RAMq;
          state_d            = ACK;
          ack_d              = cur_oh_s;
        end else begin
          cnt_d = cnt_q - CW'(1'b1);
        end
      end
      ACK: begin
        ptr_d = next_ptr_s;
        if (any_s) begin
          state_d    = ISSUE;
          g_d        = pick_idx_s;
          wr_d       = pick_wr_s;
          acq_d      = pick_oh_s;
          ram_addr_d = pick_addr_s;
          ram_din_d  = pick_wr_s ? pick_din_s : {DW{1'b0}};
          ram_wren_d = pick_wr_s;
          err_d      = err_q | pick_both_s;
        end else begin
          state_d    = IDLE;
          acq_d      = {N{1'b0}};
          ram_addr_d = {AW{1'b0}};
          ram_din_d  = {DW{1'b0}};
          ram_wren_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        acq_d      = {N{1'b0}};
        ram_addr_d = {AW{1'b0}};
        ram_din_d  = {DW{1'b0}};
        ram_wren_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any in-flight access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= {PW{1'b0}};
      g_q        <= {PW{1'b0}};
      wr_q       <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      acq_q      <= {N{1'b0}};
      ack_q      <= {N{1'b0}};
      dq_q       <= {(N*DW){1'b0}};
      ram_addr_q <= {AW{1'b0}};
      ram_din_q  <= {DW{1'b0}};
      ram_wren_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      g_q        <= g_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      acq_q      <= acq_d;
      ack_q      <= ack_d;
      dq_q       <= dq_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_wren_q <= ram_wren_d;
      err_q      <= err_d;
    end
  end

  assign acq        = acq_q;
  assign ack        = ack_q;
  assign Dq         = dq_q;
  assign RAMAddress = ram_addr_q;
  assign RAMDin     = ram_din_q;
  assign RAMwren    = ram_wren_q;
  assign err        = err_q;

endmodule
